// File: rtl/character_plane_console.sv
// Text console that turns a byte stream of character ids and control codes into
// character-plane writes, sweeping blanks over the plane or over a row when clearing.
module character_plane_console #(
  parameter int          ROWS     = 16,
  parameter int          COLS     = 40,
  parameter logic [7:0]  BLANK_ID = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] row,
  output logic [5:0] column,
  output logic [7:0] character_id,
  output logic       we,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_column,
  output logic       busy
);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_e;

  localparam logic [7:0] CODE_CLEAR     = 8'h0C;
  localparam logic [7:0] CODE_NEWLINE   = 8'h0A;
  localparam logic [7:0] CODE_BACKSPACE = 8'h08;
  localparam logic [3:0] LAST_ROW       = 4'(ROWS - 1);
  localparam logic [5:0] LAST_COL       = 6'(COLS - 1);

  state_e     state_q;
  logic [3:0] row_q, cursor_row_q, sweep_row_q;
  logic [5:0] col_q, cursor_col_q, sweep_col_q;
  logic [7:0] char_q;
  logic       we_q;
  logic       sweep_done_q;
  logic [3:0] cursor_row_next;

  assign cursor_row_next = (cursor_row_q == LAST_ROW) ? 4'd0 : cursor_row_q + 4'd1;

  // The last sweep write raises sweep_done_q so the block stays busy while that
  // write is on the bus and only returns to IDLE on the following edge.
  // NOTE: every register below is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= CLEAR_ALL;
      sweep_row_q  <= 4'd0;
      sweep_col_q  <= 6'd0;
      sweep_done_q <= 1'b0;
      cursor_row_q <= 4'd0;
      cursor_col_q <= 6'd0;
      row_q        <= 4'd0;
      col_q        <= 6'd0;
      char_q       <= BLANK_ID;
      we_q         <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        CLEAR_ALL, CLEAR_ROW: begin
          if (sweep_done_q) begin
            state_q      <= IDLE;
            sweep_done_q <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            row_q  <= sweep_row_q;
            col_q  <= sweep_col_q;
            char_q <= BLANK_ID;
            if (sweep_col_q == LAST_COL) begin
              sweep_col_q <= 6'd0;
              if (state_q == CLEAR_ROW || sweep_row_q == LAST_ROW) begin
                sweep_done_q <= 1'b1;
              end else begin
                sweep_row_q <= sweep_row_q + 4'd1;
              end
            end else begin
              sweep_col_q <= sweep_col_q + 6'd1;
            end
          end
        end

        IDLE: begin
          if (in_valid) begin
            case (in_data)
              CODE_CLEAR: begin
                state_q      <= CLEAR_ALL;
                sweep_row_q  <= 4'd0;
                sweep_col_q  <= 6'd0;
                sweep_done_q <= 1'b0;
                cursor_row_q <= 4'd0;
                cursor_col_q <= 6'd0;
              end
              CODE_NEWLINE: begin
                // Column 0 of the new row is blanked right away; the sweep resumes at column 1.
                state_q      <= CLEAR_ROW;
                cursor_row_q <= cursor_row_next;
                cursor_col_q <= 6'd0;
                we_q         <= 1'b1;
                row_q        <= cursor_row_next;
                col_q        <= 6'd0;
                char_q       <= BLANK_ID;
                sweep_row_q  <= cursor_row_next;
                sweep_col_q  <= (LAST_COL == 6'd0) ? 6'd0 : 6'd1;
                sweep_done_q <= (LAST_COL == 6'd0);
              end
              CODE_BACKSPACE: begin
                if (cursor_col_q != 6'd0) begin
                  cursor_col_q <= cursor_col_q - 6'd1;
                  we_q         <= 1'b1;
                  row_q        <= cursor_row_q;
                  col_q        <= cursor_col_q - 6'd1;
                  char_q       <= BLANK_ID;
                end else if (cursor_row_q != 4'd0) begin
                  cursor_row_q <= cursor_row_q - 4'd1;
                  cursor_col_q <= LAST_COL;
                  we_q         <= 1'b1;
                  row_q        <= cursor_row_q - 4'd1;
                  col_q        <= LAST_COL;
                  char_q       <= BLANK_ID;
                end
              end
              default: begin
                we_q   <= 1'b1;
                row_q  <= cursor_row_q;
                col_q  <= cursor_col_q;
                char_q <= in_data;
                if (cursor_col_q == LAST_COL) begin
                  state_q      <= CLEAR_ROW;
                  cursor_row_q <= cursor_row_next;
                  cursor_col_q <= 6'd0;
                  sweep_row_q  <= cursor_row_next;
                  sweep_col_q  <= 6'd0;
                  sweep_done_q <= 1'b0;
                end else begin
                  cursor_col_q <= cursor_col_q + 6'd1;
                end
              end
            endcase
          end
        end

        default: state_q <= CLEAR_ALL;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign row           = row_q;
  assign column        = col_q;
  assign character_id  = char_q;
  assign we            = we_q;
  assign cursor_row    = cursor_row_q;
  assign cursor_column = cursor_col_q;

endmodule

// File: tb/tb_character_plane_console.sv
// Directed bench for character_plane_console: plane sweep, characters, wrap,
// newline, backspace, held input during busy, and reset in the middle of a sweep.
module tb_character_plane_console;

  localparam int ROWS = 16;
  localparam int COLS = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] row;
  logic [5:0] column;
  logic [7:0] character_id;
  logic       we;
  logic [3:0] cursor_row;
  logic [5:0] cursor_column;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  character_plane_console dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .row          (row),
    .column       (column),
    .character_id (character_id),
    .we           (we),
    .cursor_row   (cursor_row),
    .cursor_column(cursor_column),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_write(input string tag, input int r, input int c, input logic [7:0] ch);
    check(tag, {13'd0, we, row, column, character_id}, {13'd0, 1'b1, 4'(r), 6'(c), ch});
  endtask

  task automatic expect_cursor(input string tag, input int r, input int c);
    check(tag, {22'd0, cursor_row, cursor_column}, {22'd0, 4'(r), 6'(c)});
  endtask

  task automatic expect_quiet_ready(input string tag);
    check(tag, {29'd0, we, in_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic accept(input logic [7:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  // n consecutive blank writes in row-major order from (0,0), block busy throughout.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("sweep", {11'd0, in_ready, busy, we, row, column, character_id},
            {11'd0, 1'b0, 1'b1, 1'b1, 4'(i / COLS), 6'(i % COLS), 8'h00});
    end
  endtask

  // Blank writes to row r from column c0 to the last column, then ready again.
  task automatic row_clear(input int r, input int c0);
    for (int c = c0; c < COLS; c++) begin
      tick();
      expect_write("row_clear", r, c, 8'h00);
      check("row_clear_busy", {31'd0, in_ready}, 32'd0);
    end
    tick();
    expect_quiet_ready("row_clear_done");
  endtask

  task automatic newline(input int new_row);
    accept(8'h0A);
    expect_write("newline_first", new_row, 0, 8'h00);
    expect_cursor("newline_cursor", new_row, 0);
    row_clear(new_row, 1);
  endtask

  initial begin
    int low_cycles;

    // Reset state
    reset = 1'b0;
    tick();
    check("reset_state", {12'd0, we, in_ready, busy, row, column, character_id},
          {12'd0, 1'b0, 1'b0, 1'b1, 4'd0, 6'd0, 8'h00});
    expect_cursor("reset_cursor", 0, 0);
    tick();
    reset = 1'b1;

    // Full plane sweep after release
    sweep(ROWS * COLS);
    tick();
    expect_quiet_ready("init_done");
    expect_cursor("init_cursor", 0, 0);

    // Back-to-back characters
    for (int k = 1; k <= 4; k++) begin
      accept(8'(k));
      expect_write("char_b2b", 0, k - 1, 8'(k));
      check("char_b2b_ready", {31'd0, in_ready}, 32'd1);
    end
    expect_cursor("cursor_after_4", 0, 4);
    tick();
    check("we_drops", {31'd0, we}, 32'd0);
    check("hold_last_write", {14'd0, row, column, character_id}, {14'd0, 4'd0, 6'd3, 8'h04});

    // Fill to the last column
    for (int c = 4; c < COLS - 1; c++) begin
      accept(8'h20 + 8'(c));
      expect_write("fill", 0, c, 8'h20 + 8'(c));
    end
    expect_cursor("cursor_last_col", 0, COLS - 1);

    // Wrapping character: char write then row 1 blanked with no gap
    accept(8'h41);
    expect_write("wrap_char", 0, COLS - 1, 8'h41);
    expect_cursor("wrap_cursor", 1, 0);
    low_cycles = (in_ready == 1'b0) ? 1 : 0;
    for (int c = 0; c < COLS; c++) begin
      tick();
      expect_write("wrap_clear", 1, c, 8'h00);
      if (!in_ready) low_cycles++;
    end
    tick();
    expect_quiet_ready("wrap_done");
    check("wrap_low_cycles", 32'(low_cycles), 32'd41);

    // Newlines down to the last row, then move to (15,5)
    for (int r = 2; r < ROWS; r++) newline(r);
    for (int c = 0; c < 5; c++) begin
      accept(8'h61 + 8'(c));
      expect_write("last_row_char", ROWS - 1, c, 8'h61 + 8'(c));
    end
    expect_cursor("cursor_15_5", ROWS - 1, 5);

    // Newline on the last row wraps to row 0
    newline(0);
    expect_cursor("cursor_wrap_home", 0, 0);

    // Backspace at home does nothing
    accept(8'h08);
    expect_quiet_ready("bs_home");
    expect_cursor("bs_home_cursor", 0, 0);

    // Backspace from column 0 of row 1 lands on (0,39)
    newline(1);
    accept(8'h08);
    expect_write("bs_row_back", 0, COLS - 1, 8'h00);
    expect_cursor("bs_row_back_cursor", 0, COLS - 1);
    check("bs_ready", {31'd0, in_ready}, 32'd1);

    // Backspace within a row
    accept(8'h08);
    expect_write("bs_col_back", 0, COLS - 2, 8'h00);
    expect_cursor("bs_col_back_cursor", 0, COLS - 2);
    accept(8'h5A);
    expect_write("refill", 0, COLS - 2, 8'h5A);

    // Input held valid while clearing a row is taken only once ready returns
    accept(8'h42);
    expect_write("hold_wrap_char", 0, COLS - 1, 8'h42);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < COLS; c++) begin
      tick();
      expect_write("hold_clear", 1, c, 8'h00);
    end
    tick();
    expect_quiet_ready("hold_ready");
    tick();
    in_valid = 1'b0;
    expect_write("hold_accept", 1, 0, 8'h55);
    expect_cursor("hold_cursor", 1, 1);
    tick();
    check("hold_single", {31'd0, we}, 32'd0);

    // Clear code, then reset in the middle of the sweep
    accept(8'h0C);
    check("clear_accept", {30'd0, we, busy}, {30'd0, 1'b0, 1'b1});
    expect_cursor("clear_cursor", 0, 0);
    sweep(300);
    reset = 1'b0;
    tick();
    check("mid_reset_state", {12'd0, we, in_ready, busy, row, column, character_id},
          {12'd0, 1'b0, 1'b0, 1'b1, 4'd0, 6'd0, 8'h00});
    expect_cursor("mid_reset_cursor", 0, 0);
    reset = 1'b1;
    sweep(ROWS * COLS);
    tick();
    expect_quiet_ready("restart_done");
    expect_cursor("restart_cursor", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/character_plane_console.md
CHARACTER_PLANE_CONSOLE -- requirements
Module: character_plane_console

Interface
REQ-001 Parameter ROWS, default 16, number of character-plane rows.
REQ-002 Parameter COLS, default 40, number of character-plane columns.
REQ-003 Parameter BLANK_ID, default 8'h00, character id written when clearing.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset: reset==0 at a rising clock edge resets the block.
REQ-006 in_data  input  8  character id or control code offered by the requester.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 row  output  4  character-plane write row.
REQ-010 column  output  6  character-plane write column.
REQ-011 character_id  output  8  character-plane write data.
REQ-012 we  output  1  character-plane write enable, one write per cycle when high.
REQ-013 cursor_row / cursor_column  output  4 / 6  current cursor position.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be CLEAR_ALL, IDLE and CLEAR_ROW.
REQ-016 Outputs row, column, character_id and we SHALL be registered: a write decided at edge k is presented in the cycle after edge k.
REQ-017 When we is low, row, column and character_id SHALL hold their last values.
REQ-018 in_ready SHALL be 1 only in IDLE; a transfer occurs at an edge where in_valid and in_ready are both 1.
REQ-019 CLEAR_ALL SHALL issue ROWS*COLS consecutive writes of BLANK_ID, row-major from (0,0) to (ROWS-1,COLS-1), one per cycle, then enter IDLE with cursor (0,0).
REQ-020 Accepted code 8'h0C (clear) SHALL enter CLEAR_ALL and set cursor (0,0).
REQ-021 Accepted code 8'h0A (newline) SHALL set cursor_column=0, cursor_row=(cursor_row+1) mod ROWS, and enter CLEAR_ROW.
REQ-022 Accepted code 8'h08 (backspace) SHALL move the cursor back one cell and write BLANK_ID there.
- Column>0: column-1.
- Column 0, row>0: (row-1, COLS-1).
- At (0,0): accepted, no write, cursor unchanged.
REQ-023 Any other accepted code SHALL be written as-is at the cursor, with the write cycle immediately after the accept edge, and then advance the cursor.
- Column<COLS-1: column+1, stay in IDLE.
- Column==COLS-1: column 0, row=(row+1) mod ROWS, enter CLEAR_ROW.
REQ-024 Row wrap from ROWS-1 SHALL go to row 0; no scrolling.
REQ-025 CLEAR_ROW SHALL issue COLS consecutive writes of BLANK_ID to the new cursor row, columns 0..COLS-1.
- After a wrapping character, these writes follow the character write with no gap.
- After a newline, they start in the cycle after the accept edge.
REQ-026 in_ready SHALL return to 1 in the cycle after the last CLEAR_ROW or CLEAR_ALL write.
REQ-027 in_valid held high during busy SHALL not be consumed; in_data SHALL be ignored until in_ready is 1.
REQ-028 Cursor outputs SHALL update at the same edge that accepts the code.

Reset
REQ-029 On reset==0 at an edge, the block SHALL enter CLEAR_ALL with sweep position (0,0).
- Cursor SHALL be set to (0,0).
- we=0, in_ready=0, busy=1.
- row=0, column=0, character_id=BLANK_ID.
REQ-030 When reset is asserted mid-operation, the block SHALL abort any in-progress clear or write and restart the full CLEAR_ALL after release.
REQ-031 The first CLEAR_ALL write SHALL appear in the cycle after the first edge with reset==1.

Verification
REQ-032 Release reset -> exactly 640 we pulses of 8'h00 covering (0,0)..(15,39) in order; in_ready=1 on the 641st cycle; cursor (0,0).
REQ-033 After init, send 1,2,3,4 back-to-back -> writes (0,0)=1, (0,1)=2, (0,2)=3, (0,3)=4 on consecutive cycles; cursor (0,4).
REQ-034 Cursor (0,39), send 8'h41 -> write (0,39)=8'h41, then 40 blank writes to row 1, in_ready low 41 cycles; cursor (1,0).
REQ-035 Cursor (15,5), send 8'h0A -> 40 blank writes to row 0; cursor (0,0). Then send 8'h08 at (0,0) -> no write; at (1,0) -> blank written at (0,39), cursor (0,39).
REQ-036 During CLEAR_ROW, hold in_valid=1 with 8'h55 -> no accept until in_ready rises, then a single write of 8'h55.
REQ-037 Assert reset at sweep write 300 of CLEAR_ALL, then release -> sweep restarts at (0,0) with a full 640 writes.
